ahb_dma_master: RTL and testbench
=================================

// Module: ahb_dma_master
// PURPOSE
//  Single-channel memory-to-memory copy engine. Masters one port of ahb_ic (upstream of the matrix).
//  Copies LEN words of 3*NBITS bits from SRC to DST as non-pipelined AHB-Lite single transfers: read beat, then write beat.
//  Lets the host core offload polynomial/coefficient moves between program RAM, on-chip RAM and the compute memories.
// PARAMETERS
//  NBITS     128      bus word = 3*NBITS bits (matches ahb_ic)
//  LEN_W     16       width of the beat-count registers
//  ADDR_INC  32'd1    haddr increment per beat (memories are word-indexed)
//  HSIZE     3'b010   constant hsize driven on every transfer
// PORTS
//  hclk         in   1          clock
//  hreset       in   1          synchronous reset, active-high
//  start        in   1          1-cycle request; ignored while busy
//  abort        in   1          level; stop at the next beat boundary
//  src_addr     in   32         first read address (sampled on accepted start)
//  dst_addr     in   32         first write address (sampled on accepted start)
//  len          in   LEN_W      number of beats (sampled on accepted start)
//  busy         out  1          high from the cycle after start until done
//  done         out  1          1-cycle pulse at completion, abort or error
//  err          out  1          sticky bus error; cleared by the next accepted start
//  err_addr     out  32         haddr of the transfer that returned an error
//  beats_done   out  LEN_W      number of beats fully written
//  htrans_m     out  2          IDLE=2'b00 or NONSEQ=2'b10 only
//  haddr_m      out  32         transfer address
//  hsize_m      out  3          = HSIZE
//  hwrite_m     out  1          1 = write
//  hwdata_m     out  3*NBITS    write data
//  hrdata_m     in   3*NBITS    read data
//  hready_m     in   1          transfer-complete/stall from ahb_ic
//  hresp_m      in   1          error response from ahb_ic
// BEHAVIOUR
//  Reset values: all outputs 0 (htrans_m = IDLE); FSM = IDLE; counters 0.
//  Reset is synchronous; asserted mid-copy -> htrans_m = IDLE at the next edge. The bus is left as-is; no completion.
//  FSM (advances only on the edges named):
//   IDLE : htrans = IDLE. start & len!=0 -> latch src/dst/len, clear err and beats_done, then RD_A.
//          start & len==0 -> done pulse next cycle, no bus traffic, busy stays 0.
//   RD_A : drive NONSEQ, haddr = rd_ptr, hwrite = 0. hready=1 -> RD_D. While hready=0, addr/ctl held stable.
//          Arbitration loss in ahb_ic shows up only as hready=0.
//   RD_D : htrans = IDLE. hready=1 & hresp=0 -> capture hrdata_m into wbuf, then WR_A.
//          hready=1 & hresp=1 -> ERR.
//   WR_A : NONSEQ, haddr = wr_ptr, hwrite = 1. hready=1 -> WR_D.
//   WR_D : htrans = IDLE, hwdata_m = wbuf, held until hready=1.
//          hready=1 & hresp=0 -> beats_done+1, rd_ptr/wr_ptr += ADDR_INC, then:
//            remaining==0 -> FIN; abort -> FIN; else RD_A.
//          hready=1 & hresp=1 -> ERR.
//   ERR  : err = 1, err_addr = address of the failing beat, then FIN.
//   FIN  : done = 1 for one cycle, busy = 0, then IDLE.
//  Latency per beat with zero wait states: 4 cycles (RD_A, RD_D, WR_A, WR_D).
//  hresp is sampled only when hready=1 in a data phase; hresp=1 with hready=0 (first error cycle) is ignored.
//  abort never withdraws an issued address phase. Abort asserted in RD_A/RD_D completes the current write first.
//  An issued but unanswered address phase is never dropped or changed.
//  Pointers wrap modulo 2^32 silently; no boundary checks.
//  beats_done never exceeds len. Simultaneous abort and last beat -> single done, beats_done = len.
//  hwdata_m = 0 outside WR_D. haddr_m/hwrite_m = 0 while htrans = IDLE.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_* constants,
//   typedef enum dma_state_t {IDLE, RD_A, RD_D, WR_A, WR_D, ERR, FIN}.
//  Single module, no sub-module: one FSM, two address pointers, one down-counter, one 3*NBITS data buffer.
// TESTING
//  1 src=0x2000_0000, dst=0x0000_0010, len=3, zero-wait slave -> 12 bus cycles.
//    Reads at 0x2000_0000..02, writes at 0x10..12 with matching data; done 1 cycle later; beats_done=3.
//  2 Slave holds hready=0 for 2 cycles in each data phase -> haddr/hwdata held stable, 8 cycles per beat, data intact.
//  3 Higher-priority master contends on ahb_ic for same slave (hready_m low in addr phase) -> no lost or duplicate beat.
//  4 Write beat 2 of len=4 returns 2-cycle error -> err=1, err_addr=dst+1, beats_done=1, done pulse, no further htrans.
//  5 abort raised during RD_D of beat 1 (len=5) -> beat 1 write completes, done, beats_done=2.
//    Also len=0 start -> done next cycle, no traffic.
//  6 hreset asserted in WR_A -> htrans=IDLE, busy=0, done=0 next edge.
//    Also start while busy -> ignored, latched params unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Purpose: shared AHB-Lite encodings and the copy-engine state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

  // htrans encodings; the copy engine only ever issues IDLE or NONSEQ
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // hsize encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // Copy-engine sequencing: address/data phase of the read beat, then of the write beat
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4,
    ERR  = 3'd5,
    FIN  = 3'd6
  } dma_state_t;

endpackage

// File: rtl/ahb_dma_master.sv
// Purpose: single-channel AHB-Lite copy engine, moves len words src -> dst as read beat then write beat.
// Latency: 4 cycles per word against a zero-wait slave; done pulses the cycle after the last write completes.
// Backpressure: hready_m low freezes the current address or data phase; abort only acts at a beat boundary.
module ahb_dma_master
  import ahb_pkg::*;
#(
  parameter int          NBITS    = 128,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] ADDR_INC = 32'd1,
  parameter logic [2:0]  HSIZE    = HSIZE_WORD
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        err_addr,
  output logic [LEN_W-1:0]   beats_done,
  output logic [1:0]         htrans_m,
  output logic [31:0]        haddr_m,
  output logic [2:0]         hsize_m,
  output logic               hwrite_m,
  output logic [3*NBITS-1:0] hwdata_m,
  input  logic [3*NBITS-1:0] hrdata_m,
  input  logic               hready_m,
  input  logic               hresp_m
);

  localparam int               DW      = 3 * NBITS;
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  dma_state_t       state;
  logic [31:0]      rd_ptr;     // address of the current read beat
  logic [31:0]      wr_ptr;     // address of the current write beat
  logic [LEN_W-1:0] remaining;  // beats still to be written, including the current one
  logic [DW-1:0]    wbuf;       // word in flight between its read and its write

  // Sequencer: every bus-facing output is registered and set on the edge that enters the state it belongs to
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      remaining  <= '0;
      wbuf       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
      beats_done <= '0;
      htrans_m   <= HTRANS_IDLE;
      haddr_m    <= '0;
      hsize_m    <= '0;
      hwrite_m   <= 1'b0;
      hwdata_m   <= '0;
    end else begin
      hsize_m <= HSIZE;
      done    <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              // Accept the job and launch the first read address phase right away
              rd_ptr     <= src_addr;
              wr_ptr     <= dst_addr;
              remaining  <= len;
              err        <= 1'b0;
              beats_done <= '0;
              busy       <= 1'b1;
              htrans_m   <= HTRANS_NONSEQ;
              haddr_m    <= src_addr;
              hwrite_m   <= 1'b0;
              state      <= RD_A;
            end else begin
              // Zero-length job: complete immediately, never touch the bus
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        RD_A: begin
          // Address/control stay frozen until the slave (or the matrix) accepts them
          if (hready_m) begin
            htrans_m <= HTRANS_IDLE;
            haddr_m  <= '0;
            state    <= RD_D;
          end
        end

        RD_D: begin
          // hresp only counts on the completing cycle of the two-cycle error response
          if (hready_m) begin
            if (hresp_m) begin
              err      <= 1'b1;
              err_addr <= rd_ptr;
              state    <= ERR;
            end else begin
              wbuf     <= hrdata_m;
              htrans_m <= HTRANS_NONSEQ;
              haddr_m  <= wr_ptr;
              hwrite_m <= 1'b1;
              state    <= WR_A;
            end
          end
        end

        WR_A: begin
          if (hready_m) begin
            htrans_m <= HTRANS_IDLE;
            haddr_m  <= '0;
            hwrite_m <= 1'b0;
            hwdata_m <= wbuf;
            state    <= WR_D;
          end
        end

        WR_D: begin
          // Write data is held until the slave completes; this is the only beat boundary
          if (hready_m) begin
            hwdata_m <= '0;
            if (hresp_m) begin
              err      <= 1'b1;
              err_addr <= wr_ptr;
              state    <= ERR;
            end else begin
              beats_done <= beats_done + LEN_ONE;
              remaining  <= remaining - LEN_ONE;
              rd_ptr     <= rd_ptr + ADDR_INC;
              wr_ptr     <= wr_ptr + ADDR_INC;
              if ((remaining == LEN_ONE) || abort) begin
                // Last beat and abort together still give exactly one done
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                htrans_m <= HTRANS_NONSEQ;
                haddr_m  <= rd_ptr + ADDR_INC;
                hwrite_m <= 1'b0;
                state    <= RD_A;
              end
            end
          end
        end

        ERR: begin
          // err/err_addr were set on entry; just report completion
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          busy     <= 1'b0;
          htrans_m <= HTRANS_IDLE;
          haddr_m  <= '0;
          hwrite_m <= 1'b0;
          hwdata_m <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Purpose: directed bench for ahb_dma_master with a reactive slave and a transfer-list model.
// Latency: n/a.
// Backpressure: slave inserts address-phase and data-phase wait states and two-cycle error responses.
module tb_ahb_dma_master;
  import ahb_pkg::*;

  localparam int         NBITS = 128;
  localparam int         DW    = 3 * NBITS;
  localparam int         LEN_W = 16;
  localparam logic [2:0] HSZ   = 3'b010;

  logic             hclk = 1'b0;
  logic             hreset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err, hwrite_m;
  logic [31:0]      err_addr, haddr_m;
  logic [LEN_W-1:0] beats_done;
  logic [1:0]       htrans_m;
  logic [2:0]       hsize_m;
  logic [DW-1:0]    hwdata_m;
  logic [DW-1:0]    hrdata_m = '0;
  logic             hready_m = 1'b1;
  logic             hresp_m = 1'b0;

  ahb_dma_master #(.NBITS(NBITS), .LEN_W(LEN_W)) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .beats_done(beats_done),
    .htrans_m(htrans_m), .haddr_m(haddr_m), .hsize_m(hsize_m), .hwrite_m(hwrite_m),
    .hwdata_m(hwdata_m), .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Source memory contents: a distinct word per address
  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {4{a, ~a, a ^ 32'h5A00_00C3}};
  endfunction

  // Model: the ordered list of bus transfers the job must produce
  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [DW-1:0] data;
    int            beat;
  } xfer_t;
  xfer_t expq[$];

  // Slave configuration and tracking
  int          wa = 0;        // address-phase wait states
  int          wd = 0;        // data-phase wait states
  int          err_xfer = -1; // index of the transfer that gets an error response
  int          xfer_idx = 0;
  int          dcnt = 0;
  int          acnt = 0;
  int          n_done = 0;
  bit          dph_vld = 1'b0;
  bit          dph_err = 1'b0;
  xfer_t       dph;
  logic [1:0]  p_htrans = HTRANS_IDLE;
  logic [31:0] p_haddr = '0;
  logic        p_hwrite = 1'b0;
  bit          found;

  // Slave + compare: retire the edge just taken, check the outputs, then answer for the next edge
  always @(negedge hclk) begin
    bit addr_stall;
    addr_stall = 1'b0;
    if (hreset) begin
      dph_vld = 1'b0; dcnt = 0; acnt = 0;
      check("reset_ctl", DW'({htrans_m, haddr_m, hwrite_m, busy, done, err, beats_done, err_addr, hsize_m}), '0);
      check("reset_wdata", hwdata_m, '0);
      hready_m = 1'b1; hresp_m = 1'b0; hrdata_m = '0;
    end else begin
      if (dph_vld) begin
        if (hready_m) dph_vld = 1'b0;
        else dcnt++;
      end else if (p_htrans == HTRANS_NONSEQ) begin
        if (hready_m) begin
          check("xfer_expected", DW'(expq.size() != 0), DW'(1));
          if (expq.size() != 0) begin
            dph = expq.pop_front();
            check("xfer_addr", DW'({p_hwrite, p_haddr}), DW'({dph.wr, dph.addr}));
            dph_err = (xfer_idx == err_xfer);
            xfer_idx++;
            dph_vld = 1'b1;
            dcnt = 0;
          end
          acnt = 0;
        end else begin
          acnt++;
          addr_stall = 1'b1;
        end
      end

      check("htrans_legal", DW'(htrans_m == HTRANS_IDLE || htrans_m == HTRANS_NONSEQ), DW'(1));
      if (htrans_m == HTRANS_IDLE) check("idle_addr_ctl", DW'({hwrite_m, haddr_m}), '0);
      else check("nonseq_ctl", DW'({busy, hsize_m}), DW'({1'b1, HSZ}));
      if (addr_stall)
        check("addr_hold", DW'({htrans_m, hwrite_m, haddr_m}), DW'({p_htrans, p_hwrite, p_haddr}));
      if (dph_vld) begin
        check("dphase_ctl", DW'({htrans_m, busy}), DW'({HTRANS_IDLE, 1'b1}));
        check("hwdata", hwdata_m, dph.wr ? dph.data : {DW{1'b0}});
      end else begin
        check("hwdata_idle", hwdata_m, '0);
      end
      if (done) begin
        n_done++;
        check("done_not_busy", DW'(busy), '0);
      end

      if (dph_vld) begin
        if (dph_err) begin hready_m = (dcnt >= 1); hresp_m = 1'b1; end
        else begin hready_m = (dcnt >= wd); hresp_m = 1'b0; end
        hrdata_m = dph.wr ? {DW{1'b0}} : pat(dph.addr);
      end else if (htrans_m == HTRANS_NONSEQ) begin
        hready_m = (acnt >= wa); hresp_m = 1'b0; hrdata_m = '0;
      end else begin
        hready_m = 1'b1; hresp_m = 1'b0; hrdata_m = '0;
      end
    end
    p_htrans = htrans_m; p_haddr = haddr_m; p_hwrite = hwrite_m;
  end

  // One copy job: build the expected transfer list, start, wait for done, check the results
  task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] d, input int n,
                         input int a_w, input int d_w, input int ex, input int ab, input bit poke,
                         input int exp_beats, input bit exp_err, input logic [31:0] exp_eaddr,
                         input int exp_cyc);
    int nb;
    int t0;
    int tdone;
    bit seen;
    if (ex >= 0) nb = ex / 2;
    else if (ab >= 0) nb = (ab + 1 < n) ? ab + 1 : n;
    else nb = n;
    expq.delete();
    for (int i = 0; i < nb; i++) begin
      expq.push_back('{1'b0, s + 32'(i), {DW{1'b0}}, i});
      expq.push_back('{1'b1, d + 32'(i), pat(s + 32'(i)), i});
    end
    if (ex >= 0) begin
      expq.push_back('{1'b0, s + 32'(nb), {DW{1'b0}}, nb});
      if (ex % 2 == 1) expq.push_back('{1'b1, d + 32'(nb), pat(s + 32'(nb)), nb});
    end
    wa = a_w; wd = d_w; err_xfer = ex; xfer_idx = 0; n_done = 0;
    src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1; t0 = cyc;
    seen = 1'b0; tdone = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge hclk); #1;
      if (k == 0) start = 1'b0;
      if (poke && k == 4) begin
        src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; len = LEN_W'(9); start = 1'b1;
      end
      if (poke && k == 5) start = 1'b0;
      if (ab >= 0 && dph_vld && !dph.wr && dph.beat == ab) abort = 1'b1;
      if (n == 0) check({tag, "_len0_busy"}, DW'(busy), '0);
      if (done) begin seen = 1'b1; tdone = cyc; end
    end
    abort = 1'b0;
    check({tag, "_done"}, DW'(seen), DW'(1));
    if (exp_cyc >= 0) check({tag, "_cycles"}, DW'(tdone - t0), DW'(exp_cyc));
    if (exp_beats >= 0) check({tag, "_beats_done"}, DW'(beats_done), DW'(exp_beats));
    repeat (4) @(negedge hclk);
    #1;
    check({tag, "_single_done"}, DW'(n_done), DW'(1));
    check({tag, "_all_xfers"}, DW'(expq.size()), '0);
    check({tag, "_err"}, DW'(err), DW'(exp_err));
    if (exp_err) check({tag, "_err_addr"}, DW'(err_addr), DW'(exp_eaddr));
  endtask

  initial begin
    hreset = 1'b1;
    repeat (3) @(negedge hclk);
    #1 hreset = 1'b0;

    //       tag          src            dst            len wa wd err abt poke beats err eaddr          cycles
    run_job("t1_basic",  32'h2000_0000, 32'h0000_0010, 3,  0, 0, -1, -1, 0,   3,    0,  32'h0,         13);
    run_job("t2_dwait",  32'h2000_0100, 32'h0000_0040, 2,  0, 2, -1, -1, 1,   2,    0,  32'h0,         17);
    run_job("t3_await",  32'h3000_0000, 32'h0000_0080, 3,  2, 0, -1, -1, 0,   3,    0,  32'h0,         25);
    run_job("t4_werr",   32'h2000_0200, 32'h0000_0100, 4,  0, 0,  3, -1, 0,   1,    1,  32'h0000_0101, -1);
    run_job("t4b_rerr",  32'h2000_0400, 32'h0000_0300, 3,  0, 1,  2, -1, 0,   1,    1,  32'h2000_0401, -1);
    run_job("t5_abort",  32'h2000_0300, 32'h0000_0200, 5,  0, 0, -1,  1, 0,   2,    0,  32'h0,         9);
    run_job("t5_len0",   32'h2000_0000, 32'h0000_0000, 0,  0, 0, -1, -1, 0,   -1,   0,  32'h0,         1);
    run_job("t5_lastab", 32'h2000_0500, 32'h0000_0500, 2,  0, 0, -1,  1, 0,   2,    0,  32'h0,         9);
    run_job("wrap",      32'hFFFF_FFFF, 32'hFFFF_FFFE, 3,  0, 0, -1, -1, 0,   3,    0,  32'h0,         13);

    // Reset while a write address phase is outstanding
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      expq.push_back('{1'b0, 32'h500 + 32'(i), {DW{1'b0}}, i});
      expq.push_back('{1'b1, 32'h600 + 32'(i), pat(32'h500 + 32'(i)), i});
    end
    wa = 0; wd = 0; err_xfer = -1; xfer_idx = 0;
    src_addr = 32'h500; dst_addr = 32'h600; len = LEN_W'(3); start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge hclk); #1;
      start = 1'b0;
      if (htrans_m == HTRANS_NONSEQ && hwrite_m) found = 1'b1;
    end
    check("t6_reach_wr_a", DW'(found), DW'(1));
    hreset = 1'b1;
    @(negedge hclk); #1;
    check("t6_reset_idle", DW'({htrans_m, busy, done}), '0);
    hreset = 1'b0;
    expq.delete();
    run_job("t6_recover", 32'h0000_0040, 32'h0000_0050, 1, 0, 0, -1, -1, 0, 1, 0, 32'h0, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
